// File: rtl/cnn_pkg.sv
// Shared helpers for the conv datapath: default geometry, packed widths and
// the (ky,kx,c) element placement used by every window producer/consumer.
package cnn_pkg;

    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_CHANNELS    = 1;
    localparam int DEF_ROW_SIZE    = 28;
    localparam int DEF_COLUMN_SIZE = 28;
    localparam int DEF_STRIDE      = 1;

    // PIXEL_W: one pixel with all channels packed, channel 0 in the low bits.
    function automatic int pixel_w(input int channels, input int data_width);
        return channels * data_width;
    endfunction

    // WINDOW_W: a full KxK window of packed pixels.
    function automatic int window_w(input int k, input int channels, input int data_width);
        return k * k * channels * data_width;
    endfunction

    // Bit offset of element (ky,kx,c); ky=0 is the oldest row, kx=0 the leftmost column.
    function automatic int elem_off(input int k, input int channels, input int data_width,
                                    input int ky, input int kx, input int c);
        return ((ky * k + kx) * channels + c) * data_width;
    endfunction

    // Last coordinate along one axis that a stride-aligned window can end on.
    function automatic int last_hit(input int size, input int k, input int stride);
        return (k - 1) + stride * ((size - k) / stride);
    endfunction

endpackage

// File: rtl/window_line_buffer.sv
// One image row of delay: dout is the value written DEPTH enables ago.
// Read-before-write on a wrapping pointer, so it maps onto a simple RAM.
module window_line_buffer #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             sreset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    assign dout = mem_q[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!sreset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Contents are deliberately not cleared; stale rows are masked upstream.
    always_ff @(posedge clock) begin
        if (en) begin
            mem_q[ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sliding_window_gen.sv
// Streaming KxK x CHANNELS window generator with stride, row-edge masking,
// valid/ready on both sides and a per-frame last-window flag.
module sliding_window_gen
    import cnn_pkg::*;
#(
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int ROW_SIZE    = DEF_ROW_SIZE,
    parameter int COLUMN_SIZE = DEF_COLUMN_SIZE,
    parameter int STRIDE      = DEF_STRIDE
) (
    input  logic                                                      clock,
    input  logic                                                      sreset_n,
    input  logic                                                      in_valid,
    output logic                                                      in_ready,
    input  logic [pixel_w(CHANNELS, DATA_WIDTH)-1:0]                  in_data,
    output logic                                                      out_valid,
    input  logic                                                      out_ready,
    output logic [window_w(KERNEL_SIZE, CHANNELS, DATA_WIDTH)-1:0]    out_window,
    output logic                                                      out_last
);

    localparam int PIXEL_W = pixel_w(CHANNELS, DATA_WIDTH);
    localparam int K       = KERNEL_SIZE;
    localparam int COL_W   = $clog2(ROW_SIZE);
    localparam int ROW_W   = $clog2(COLUMN_SIZE);
    localparam int PH_W    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [COL_W-1:0] COL_MAX   = COL_W'(ROW_SIZE - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(last_hit(ROW_SIZE, K, STRIDE));
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(COLUMN_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(last_hit(COLUMN_SIZE, K, STRIDE));
    localparam logic [PH_W-1:0]  PH_MAX    = PH_W'(STRIDE - 1);

    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [PH_W-1:0]    col_ph_q, col_ph_d;
    logic [PH_W-1:0]    row_ph_q, row_ph_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [PIXEL_W-1:0] win_q [K][K];
    logic [PIXEL_W-1:0] win_d [K][K];
    logic [PIXEL_W-1:0] lb_out [K-1];
    logic [PIXEL_W-1:0] new_col [K];
    logic               accept;
    logic               col_hit;
    logic               row_hit;
    logic               emit;
    logic               is_last;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    // Cascaded line buffers: buffer gi holds the row that is gi+1 rows old.
    genvar gi, gk;
    generate
        for (gi = 0; gi < K - 1; gi++) begin : g_lb
            logic [PIXEL_W-1:0] lb_in;
            if (gi == 0) begin : g_head
                assign lb_in = in_data;
            end else begin : g_tail
                assign lb_in = lb_out[gi-1];
            end
            window_line_buffer #(
                .DEPTH (ROW_SIZE),
                .WIDTH (PIXEL_W)
            ) u_lb (
                .clock    (clock),
                .sreset_n (sreset_n),
                .en       (accept),
                .din      (lb_in),
                .dout     (lb_out[gi])
            );
        end

        for (gi = 0; gi < K - 1; gi++) begin : g_col
            assign new_col[gi] = lb_out[K-2-gi];
        end
        assign new_col[K-1] = in_data;

        for (gi = 0; gi < K; gi++) begin : g_pack_y
            for (gk = 0; gk < K; gk++) begin : g_pack_x
                assign out_window[elem_off(K, CHANNELS, DATA_WIDTH, gi, gk, 0) +: PIXEL_W] = win_q[gi][gk];
            end
        end
    endgenerate

    // Phases stay 0 until the axis reaches K-1, then count modulo STRIDE.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        col_ph_d = col_ph_q;
        row_ph_d = row_ph_q;
        if (accept) begin
            if (col_q == COL_MAX) begin
                col_d    = '0;
                col_ph_d = '0;
                if (row_q == ROW_MAX) begin
                    row_d    = '0;
                    row_ph_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                    if (row_q < ROW_FIRST || row_ph_q == PH_MAX) begin
                        row_ph_d = '0;
                    end else begin
                        row_ph_d = row_ph_q + 1'b1;
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
                if (col_q < COL_FIRST || col_ph_q == PH_MAX) begin
                    col_ph_d = '0;
                end else begin
                    col_ph_d = col_ph_q + 1'b1;
                end
            end
        end
    end

    assign col_hit = (col_q >= COL_FIRST) && (col_ph_q == '0);
    assign row_hit = (row_q >= ROW_FIRST) && (row_ph_q == '0);
    assign emit    = accept && col_hit && row_hit;
    assign is_last = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_last_d  = is_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_comb begin
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
                win_d[ky][kx] = win_q[ky][kx];
            end
        end
        if (accept) begin
            for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K - 1; kx++) begin
                    win_d[ky][kx] = win_q[ky][kx+1];
                end
                win_d[ky][K-1] = new_col[ky];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!sreset_n) begin
            col_q       <= '0;
            row_q       <= '0;
            col_ph_q    <= '0;
            row_ph_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K; kx++) begin
                    win_q[ky][kx] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            col_ph_q    <= col_ph_d;
            row_ph_q    <= row_ph_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K; kx++) begin
                    win_q[ky][kx] <= win_d[ky][kx];
                end
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Bench for sliding_window_gen: stride-1 and stride-2 instances, 3x3 on a
// 5x5 frame with two channels, checked every cycle against a frame model.
module tb_sliding_window_gen;

    localparam int K    = 3;
    localparam int R    = 5;
    localparam int C    = 5;
    localparam int DW   = 16;
    localparam int CH   = 2;
    localparam int PW   = CH * DW;
    localparam int WW   = K * K * PW;
    localparam int NPIX = R * C;

    logic          clock = 1'b0;
    logic          sreset_n = 1'b0;
    logic          a_in_valid = 1'b0;
    logic          b_in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          out_ready = 1'b1;
    logic          a_in_ready, a_out_valid, a_out_last;
    logic          b_in_ready, b_out_valid, b_out_last;
    logic [WW-1:0] a_out_window, b_out_window;

    always #5 clock = ~clock;

    sliding_window_gen #(
        .KERNEL_SIZE (K), .DATA_WIDTH (DW), .CHANNELS (CH),
        .ROW_SIZE (R), .COLUMN_SIZE (C), .STRIDE (1)
    ) dut_a (
        .clock (clock), .sreset_n (sreset_n),
        .in_valid (a_in_valid), .in_ready (a_in_ready), .in_data (in_data),
        .out_valid (a_out_valid), .out_ready (out_ready),
        .out_window (a_out_window), .out_last (a_out_last)
    );

    sliding_window_gen #(
        .KERNEL_SIZE (K), .DATA_WIDTH (DW), .CHANNELS (CH),
        .ROW_SIZE (R), .COLUMN_SIZE (C), .STRIDE (2)
    ) dut_b (
        .clock (clock), .sreset_n (sreset_n),
        .in_valid (b_in_valid), .in_ready (b_in_ready), .in_data (in_data),
        .out_valid (b_out_valid), .out_ready (out_ready),
        .out_window (b_out_window), .out_last (b_out_last)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    bit            sel = 1'b0;
    int            stride = 1;
    bit            exp_valid = 1'b0;
    bit            exp_last = 1'b0;
    logic [WW-1:0] exp_window = '0;
    int            pos = 0;
    int            n_acc = 0;
    int            dut_hs = 0;
    int            dut_lasts = 0;
    logic [PW-1:0] frame_pix [NPIX];

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit qualifies(input int row, input int col);
        return row >= K - 1 && col >= K - 1 &&
               (row - (K - 1)) % stride == 0 && (col - (K - 1)) % stride == 0;
    endfunction

    function automatic bit last_in_frame(input int row, input int col);
        for (int p = row * R + col + 1; p < NPIX; p++) begin
            if (qualifies(p / R, p % R)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock of stimulus; the frame model predicts the outputs after the edge.
    task automatic step(input bit v, input logic [PW-1:0] d, input bit rdy);
        bit            exp_rdy, acc, q;
        int            row, col;
        logic [WW-1:0] w;
        logic [PW-1:0] px;
        row = 0; col = 0; w = '0; q = 1'b0;
        a_in_valid = v && !sel;
        b_in_valid = v && sel;
        in_data    = d;
        out_ready  = rdy;
        #1;
        exp_rdy = !exp_valid || rdy;
        chk("in_ready", sel ? b_in_ready : a_in_ready, exp_rdy);
        if ((sel ? b_out_valid : a_out_valid) && rdy) begin
            dut_hs++;
            if (sel ? b_out_last : a_out_last) dut_lasts++;
        end
        acc = v && exp_rdy;
        if (acc) begin
            row = pos / R;
            col = pos % R;
            frame_pix[pos] = d;
            q = qualifies(row, col);
            if (q) begin
                for (int ky = 0; ky < K; ky++) begin
                    for (int kx = 0; kx < K; kx++) begin
                        px = frame_pix[(row - (K - 1) + ky) * R + col - (K - 1) + kx];
                        for (int c = 0; c < CH; c++) begin
                            w[((ky * K + kx) * CH + c) * DW +: DW] = px[c * DW +: DW];
                        end
                    end
                end
            end
            pos = (pos + 1) % NPIX;
            n_acc++;
        end
        @(posedge clock);
        if (q) begin
            exp_valid  = 1'b1;
            exp_window = w;
            exp_last   = last_in_frame(row, col);
        end else if (rdy) begin
            exp_valid = 1'b0;
        end
        #1;
        chk("out_valid", sel ? b_out_valid : a_out_valid, exp_valid);
        if (exp_valid) begin
            chk("out_window", sel ? b_out_window : a_out_window, exp_window);
            chk("out_last", sel ? b_out_last : a_out_last, exp_last);
        end
    endtask

    task automatic do_reset();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        out_ready  = 1'b1;
        sreset_n   = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        exp_valid = 1'b0;
        pos = 0;
        chk("rst_out_valid", sel ? b_out_valid : a_out_valid, 1'b0);
        chk("rst_out_last", sel ? b_out_last : a_out_last, 1'b0);
        chk("rst_out_window", sel ? b_out_window : a_out_window, '0);
        sreset_n = 1'b1;
    endtask

    // Directed pixels carry their frame position (ch0) and position+100 (ch1).
    task automatic stream(input int n, input bit rnd, input int stall_lo, input int stall_hi);
        int target;
        int cyc;
        target = n_acc + n;
        cyc = 0;
        while (n_acc < target && cyc < 2000) begin
            if (rnd) begin
                step($urandom_range(0, 3) != 0, PW'($urandom), $urandom_range(0, 3) != 0);
            end else begin
                step(1'b1, {16'(pos + 100), 16'(pos)}, !(cyc >= stall_lo && cyc < stall_hi));
            end
            cyc++;
        end
        chk("stream_accepts", n_acc, target);
    endtask

    task automatic drain_and_count(input int windows, input int lasts);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("window_count", dut_hs, windows);
        chk("last_count", dut_lasts, lasts);
        dut_hs = 0;
        dut_lasts = 0;
    endtask

    initial begin
        sel = 1'b0;
        stride = 1;
        do_reset();
        // Two back-to-back frames, then reset part-way into a third.
        stream(2 * NPIX, 1'b0, -1, -1);
        drain_and_count(18, 2);
        stream(8, 1'b0, -1, -1);
        do_reset();
        // Consumer stalls for three cycles right as the first window appears.
        stream(NPIX, 1'b0, 13, 16);
        drain_and_count(9, 1);
        stream(NPIX, 1'b1, -1, -1);
        drain_and_count(9, 1);

        sel = 1'b1;
        stride = 2;
        do_reset();
        stream(NPIX, 1'b0, -1, -1);
        drain_and_count(4, 1);
        stream(NPIX, 1'b1, -1, -1);
        drain_and_count(4, 1);
        stream(NPIX, 1'b1, -1, -1);
        drain_and_count(4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sliding_window_gen.md
Name: sliding_window_gen

Overview:
Streaming KxK window generator for the conv datapath. It is the successor to the fixed line-buffer image buffer and adds four things:
- multi-channel pixels
- configurable stride
- valid/ready backpressure on both sides
- exact row-edge masking, so no window ever straddles two image rows

Raster-order pixels enter; one packed KxK x CHANNELS window leaves per legal output position, with a last-window flag per frame.

Parameters:
KERNEL_SIZE, 3, window edge K (>=2)
DATA_WIDTH, 16, bits per channel sample
CHANNELS, 1, samples packed per pixel
ROW_SIZE, 28, pixels per image row (>=K)
COLUMN_SIZE, 28, rows per frame (>=K)
STRIDE, 1, window step in x and y (1..K)

Ports:
clock  in  1  rising-edge clock
sreset_n  in  1  synchronous active-low reset
in_valid  in  1  pixel present
in_ready  out  1  block accepts pixel this cycle
in_data  in  CHANNELS*DATA_WIDTH  pixel; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  1  window present
out_ready  in  1  consumer accepts window
out_window  out  K*K*CHANNELS*DATA_WIDTH  element (ky,kx,c) at offset ((ky*K+kx)*CHANNELS+c)*DATA_WIDTH; ky=0 is the top (oldest) row, kx=0 is the leftmost column
out_last  out  1  qualifies the final window of a frame; meaningful only with out_valid

Behaviour:
Interface: reset sreset_n, synchronous, active-low; clock clock.

Reset values:
- out_valid=0, out_last=0, out_window=0.
- Column/row/stride-phase counters = 0.
- Line-buffer RAM contents are not cleared; stale data is masked by the row count.

Handshake:
- A pixel is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready, combinational from the output register state.
- While stalled (out_valid && !out_ready), out_window and out_last stay stable and nothing shifts.

Storage:
- K-1 line buffers, each ROW_SIZE deep and CHANNELS*DATA_WIDTH wide.
- A KxK register window.
- On each accept: every window row shifts left by one column. The new right column is {line buffer K-2 output, ..., line buffer 0 output, in_data}, ordered top to bottom.
- The line buffers advance only on accept.

Position tracking:
- col counts 0..ROW_SIZE-1 and row counts 0..COLUMN_SIZE-1 for the accepted pixel.
- col wraps to 0 and increments row. At col=ROW_SIZE-1, row=COLUMN_SIZE-1 both wrap to 0, so back-to-back frames need no idle cycle.

Emit rule:
- An accept at (row,col) produces a window if all of the following hold: row>=K-1, col>=K-1, (row-(K-1)) mod STRIDE==0, (col-(K-1)) mod STRIDE==0.
- Implement the mod tests with phase counters, not dividers.
- Latency: out_valid rises on the cycle after the qualifying accept, and the window contains that pixel at (K-1,K-1).
- out_valid clears on out_ready unless a new qualifying accept happens in the same cycle. In that case it stays 1 with the new data (full throughput).

out_last:
- Set with the window produced by the accept at row=COLUMN_SIZE-1, col=ROW_SIZE-1, if that position qualifies.
- Otherwise set on the last qualifying position of the frame.

Other edges:
- A window whose left column would wrap from the previous row is never emitted (col<K-1 masked).
- Reset mid-frame: the next accepted pixel is treated as (0,0).
- in_valid deasserted mid-row: state holds with no timing dependency.

Decomposition:
- Shared package cnn_pkg: PIXEL_W = CHANNELS*DATA_WIDTH, WINDOW_W, and the index function elem_off(ky,kx,c).
- One sub-module, window_line_buffer: a ROW_SIZE-deep, enable-gated, single-clock delay line (register array or inferred SRAM with a read-before-write wrap pointer), instantiated K-1 times.

Test Plan:
1. K=3, ROW=COL=5, S=1, CHANNELS=1, pixel value = raster index, out_ready=1 → 9 windows. First window appears the cycle after pixel 12 is accepted, elements in offset order = 0,1,2,5,6,7,10,11,12. Only the ninth window has out_last=1 (contents ending 24).
2. Same config, checking row-edge masking → no out_valid after accepts of pixels 15 or 16. A window follows pixel 17 with elements 5,6,7,10,11,12,15,16,17.
3. S=2 → exactly 4 windows, emitted after pixels 12, 14, 22, 24; out_last only on the window after pixel 24.
4. Backpressure: out_ready low for 3 cycles while out_valid=1 and in_valid=1 → in_ready=0, out_window stable, no pixel lost. The full window sequence is identical to scenario 1.
5. CHANNELS=2, channel1 = index+100 → element (0,0) of the first window is {100,0}, with channel 0 at the low bits.
6. Two frames streamed back-to-back, plus a reset pulse after pixel 8 of a third frame → the second frame's first window follows global pixel 37 with contents equal to frame 1. After the reset, the next pixel restarts at (0,0) and behaves as scenario 1.
